udcount_seq: RTL and testbench

Move-to-target sequencer for the 4-bit up/down counter datapath. Two requesters each submit a target value over a valid/ready handshake. A round-robin arbiter grants one command at a time. The sequencer then steps an embedded enable-gated up/down counter one count per cycle, taking the shortest wrap-around direction, and signals completion with a one-cycle `done` pulse tagged with the requester id.

---
 rtl/udcount_pkg.sv | 12 +
 rtl/udcount_seq_udcounter_en.sv | 34 +++
 rtl/udcount_seq.sv | 143 ++++++++++++++
 tb/tb_udcount_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/udcount_pkg.sv
// Shared types and constants for the move-to-target counter sequencer.
package udcount_pkg;

  localparam int UDC_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/udcount_seq_udcounter_en.sv
// Enable-gated W-bit up/down counter that wraps modulo 2^W.
module udcounter_en
  import udcount_pkg::*;
#(
  parameter int W = UDC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = up_dn ? count_q + W'(1) : count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/udcount_seq.sv
// Two-requester move-to-target sequencer: round-robin grant, shortest-direction
// stepping of the embedded counter, and a tagged one-cycle done pulse.
module udcount_seq
  import udcount_pkg::*;
#(
  parameter int W = UDC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_target,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_target,
  output logic         req1_ready,
  input  logic         abort,
  output logic [W-1:0] count,
  output logic         up_dn,
  output logic         busy,
  output logic         done,
  output logic         done_id
);

  state_e       state_q, state_d;
  logic         rr_q, rr_d;
  logic [W-1:0] target_q, target_d;
  logic         id_q, id_d;
  logic         up_dn_q, up_dn_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         done_id_q, done_id_d;

  logic         grant_id;
  logic         accept;
  logic         cnt_en;
  logic [W-1:0] cnt_val;
  logic [W-1:0] step_val;
  logic [W-1:0] sel_target;
  logic [W-1:0] dist_up;
  logic [W-1:0] dist_dn;
  logic         sel_up;

  udcounter_en #(.W(W)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .up_dn (up_dn_q),
    .count (cnt_val)
  );

  // rr_q names the requester favoured when both ask at once.
  always_comb begin
    grant_id = rr_q;
    if (req0_valid && !req1_valid) begin
      grant_id = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && !rst && req0_valid && !grant_id;
  assign req1_ready = (state_q == IDLE) && !rst && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;

  assign sel_target = grant_id ? req1_target : req0_target;
  assign dist_up    = sel_target - cnt_val;
  assign dist_dn    = cnt_val - sel_target;
  assign sel_up     = (dist_up <= dist_dn);

  // Value the counter will hold after this cycle's step, used to spot arrival.
  assign step_val = up_dn_q ? cnt_val + W'(1) : cnt_val - W'(1);
  assign cnt_en   = (state_q == RUN) && !abort;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    target_d = target_q;
    id_d     = id_q;
    up_dn_d  = up_dn_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = sel_target;
          id_d     = grant_id;
          up_dn_d  = sel_up;
          rr_d     = ~grant_id;
          state_d  = (sel_target == cnt_val) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step_val == target_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    done_id_d = (state_d == DONE) ? id_d : done_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      target_q  <= '0;
      id_q      <= 1'b0;
      up_dn_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      target_q  <= target_d;
      id_q      <= id_d;
      up_dn_q   <= up_dn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign count   = cnt_val;
  assign up_dn   = up_dn_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

  a_ready_idle_only : assert property (@(posedge clk) disable iff (rst)
    (req0_ready || req1_ready) |-> (state_q == IDLE));

  a_done_single : assert property (@(posedge clk) disable iff (rst)
    done_q |=> !done_q);

endmodule

// File: tb/tb_udcount_seq.sv
// Randomized self-checking bench for udcount_seq against a transaction-level model.
module tb_udcount_seq;

  localparam int W = 4;
  localparam int MOD = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, abort;
  logic [W-1:0] req0_target, req1_target;
  logic         req0_ready, req1_ready;
  logic [W-1:0] count;
  logic         up_dn, busy, done, done_id;

  int tests = 0;
  int fails = 0;
  int mcount;
  bit mptr;

  udcount_seq #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_target (req0_target),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_target (req1_target),
    .req1_ready  (req1_ready),
    .abort       (abort),
    .count       (count),
    .up_dn       (up_dn),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_target = '0;
    req1_target = '0;
    abort = 1'b0;
    #1;
    checkOutput("rdy0_in_rst", req0_ready, 0);
    checkOutput("rdy1_in_rst", req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_updn", up_dn, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_doneid", done_id, 0);
    mcount = 0;
    mptr = 1'b0;
  endtask

  // act: 0 none, 1 abort, 2 reset; applied once actStep steps have been taken.
  task automatic applyStimulus(input bit v0, input bit v1, input logic [W-1:0] t0,
                               input logic [W-1:0] t1, input bit hold, input int act,
                               input int actStep, input bit sideAbort);
    int gid, tgt, du, dd, d;
    bit up;
    req0_valid = v0;
    req1_valid = v1;
    req0_target = t0;
    req1_target = t1;
    abort = sideAbort;
    gid = (v0 && v1) ? int'(mptr) : (v0 ? 0 : 1);
    tgt = (gid == 1) ? int'(t1) : int'(t0);
    #1;
    checkOutput("busy_idle", busy, 0);
    checkOutput("rdy0", req0_ready, v0 && gid == 0);
    checkOutput("rdy1", req1_ready, v1 && gid == 1);
    du = ((tgt - mcount) % MOD + MOD) % MOD;
    dd = ((mcount - tgt) % MOD + MOD) % MOD;
    up = (du <= dd);
    d = up ? du : dd;
    mptr = (gid == 0);
    @(negedge clk);
    abort = 1'b0;
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    checkOutput("busy_acc", busy, 1);
    checkOutput("updn_acc", up_dn, up);
    checkOutput("cnt_acc", count, mcount);
    if (d > 0) checkOutput("done_early", done, 0);
    for (int k = 0; k < d; k++) begin
      checkOutput("rdy_run", req0_ready || req1_ready, 0);
      if (act == 1 && k == actStep) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_cnt", count, mcount);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        return;
      end
      if (act == 2 && k == actStep) begin
        rst = 1'b1;
        #1;
        checkOutput("rdy_midrst", req0_ready || req1_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        mcount = 0;
        mptr = 1'b0;
        checkOutput("midrst_cnt", count, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_updn", up_dn, 1);
        @(negedge clk);
        checkOutput("midrst_nodone", done, 0);
        checkOutput("midrst_cnt2", count, 0);
        return;
      end
      @(negedge clk);
      mcount = up ? (mcount + 1) % MOD : (mcount + MOD - 1) % MOD;
      checkOutput("step_cnt", count, mcount);
      checkOutput("step_updn", up_dn, up);
      if (k < d - 1) begin
        checkOutput("step_done", done, 0);
        checkOutput("step_busy", busy, 1);
      end
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("done_id", done_id, gid);
    checkOutput("done_busy", busy, 1);
    checkOutput("rdy_done", req0_ready || req1_ready, 0);
    abort = sideAbort;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("post_done", done, 0);
    checkOutput("post_busy", busy, 0);
    checkOutput("post_cnt", count, mcount);
  endtask

  initial begin
    doReset();
    applyStimulus(1, 0, 4'd5, 4'd0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4'd0, 4'd2, 0, 0, 0, 0);
    applyStimulus(0, 1, 4'd0, 4'd14, 0, 0, 0, 0);
    applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 0, 0);
    applyStimulus(1, 0, 4'd8, 4'd0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4'd0, 4'd8, 0, 0, 0, 0);

    doReset();
    applyStimulus(1, 0, 4'd6, 4'd0, 0, 1, 2, 0);
    applyStimulus(1, 0, 4'd7, 4'd0, 0, 2, 2, 0);

    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 4'd3, 4'd9, 1, 0, 0, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    for (int i = 0; i < 60; i++) begin
      int v, r;
      v = $urandom_range(1, 3);
      r = $urandom_range(0, 9);
      applyStimulus(v[0], v[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), (r == 0) ? 1 : ((r == 1) ? 2 : 0),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
